// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester arbiter: sizes, state encoding, one-hot helper.
// Used by req_arbiter_4 (optional ROUND_ROBIN_EN build) and prio_pick4.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] PARK = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StBusy = BUSY,
    StPark = PARK
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational 4:1 priority pick: searches downward from i_start, wrapping 0 -> 3.
// o_found is low (and o_idx meaningless) when no request bit is set.
module prio_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [IDX_W-1:0] w_cand;

  // Walk from the lowest-priority slot up to i_start so the highest-priority hit wins last.
  always_comb begin
    o_idx   = i_start;
    o_found = 1'b0;
    w_cand  = i_start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = i_start - IDX_W'(k);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with hold timeout and a one-cycle PARK gap between owners.
// Define ROUND_ROBIN_EN for rotating priority; otherwise req[3] > req[2] > req[1] > req[0].
module req_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid,
  output logic             o_no_req
);

  arb_state_e       r_state, w_state_d;
  logic [N_REQ-1:0] r_gnt, w_gnt_d;
  logic [IDX_W-1:0] r_idx, w_idx_d;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_d;
  logic             r_no_req;

  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_found;
  logic             w_grant;
  logic             w_owner_req;
  logic             w_others;
  logic             w_timeout;

  prio_pick4 u_pick (
    .i_req   (i_req),
    .i_start (w_start),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

`ifdef ROUND_ROBIN_EN
  // r_rr_ptr remembers the last owner; the search begins one slot below it.
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_pick_idx;
    end
  end

  assign w_start = r_rr_ptr - IDX_W'(1);
`else
  assign w_start = IDX_W'(N_REQ - 1);
`endif

  assign w_owner_req = i_req[r_idx];
  assign w_others    = |(i_req & ~r_gnt);
  assign w_timeout   = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_idx_d   = r_idx;
    w_hold_d  = r_hold_cnt;
    w_grant   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable && w_found) begin
          w_state_d = StBusy;
          w_gnt_d   = idx_to_onehot(w_pick_idx);
          w_idx_d   = w_pick_idx;
          w_hold_d  = '0;
          w_grant   = 1'b1;
        end
      end
      StBusy: begin
        if (!w_owner_req || !i_enable || (w_timeout && w_others)) begin
          w_state_d = StPark;
          w_gnt_d   = '0;
          w_hold_d  = '0;
        end else if (!w_timeout) begin
          w_hold_d = r_hold_cnt + CNT_W'(1);
        end
      end
      StPark: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
        w_hold_d  = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
        w_hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_idx      <= '0;
      r_hold_cnt <= '0;
      r_no_req   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_idx      <= w_idx_d;
      r_hold_cnt <= w_hold_d;
      r_no_req   <= i_enable && (i_req == '0);
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_idx;
  assign o_gnt_valid = |r_gnt;
  assign o_no_req    = r_no_req;

endmodule
